// File: rtl/ahb2apb_bridge_mslv.sv
// ============================================================================
// ahb2apb_bridge_mslv
// ----------------------------------------------------------------------------
// AHB-Lite slave to APB4 master bridge serving up to NUM_SLAVES peripherals.
// One AHB transfer maps to one APB transfer. The APB side advances only on
// clock edges where PCLKEN is high. Slave errors and accesses to unmapped
// slave indices are returned as a two-cycle AHB ERROR response.
//
// Ports
//   HCLK, HRESET              clock, synchronous active-high reset
//   HSEL..HREADY              AHB-Lite slave-side request inputs
//   HREADYOUT, HRESP, HRDATA  AHB-Lite response outputs
//   PCLKEN                    APB clock enable strobe
//   PSEL..PPROT               APB4 master request outputs (PSEL one-hot)
//   PRDATA, PREADY, PSLVERR   per-slave APB responses, packed by slave index
//   APBACTIVE                 high while a transfer is in flight
// ============================================================================
module ahb2apb_bridge_mslv #(
    parameter int ADDRWIDTH    = 16,
    parameter int DATAWIDTH    = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int SLV_ADDR_LSB = 12
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             HSEL,
    input  logic [ADDRWIDTH-1:0]             HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic [2:0]                       HSIZE,
    input  logic [3:0]                       HPROT,
    input  logic [DATAWIDTH-1:0]             HWDATA,
    input  logic                             HREADY,
    output logic                             HREADYOUT,
    output logic                             HRESP,
    output logic [DATAWIDTH-1:0]             HRDATA,
    input  logic                             PCLKEN,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDRWIDTH-1:0]             PADDR,
    output logic                             PWRITE,
    output logic [DATAWIDTH-1:0]             PWDATA,
    output logic [DATAWIDTH/8-1:0]           PSTRB,
    output logic [2:0]                       PPROT,
    input  logic [NUM_SLAVES*DATAWIDTH-1:0]  PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic                             APBACTIVE
);

    localparam int NBYTES    = DATAWIDTH / 8;
    localparam int LANE_SPAN = 2 ** $clog2(NBYTES);
    localparam int IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ADDRWIDTH-1:0]   addr_reg;
    logic                   write_reg;
    logic [2:0]             size_reg;
    logic [1:0]             prot_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic                   pend_first;

    logic                   accept;
    logic                   idx_valid;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATAWIDTH-1:0]   sel_rdata;
    logic [NUM_SLAVES-1:0]  sel_onehot;
    logic [NBYTES-1:0]      strb_calc;

    // HPROT[3:2] and HTRANS[0] carry no meaning on the APB side.
    logic                   unused_inputs;
    assign unused_inputs = &{1'b0, HPROT[3:2], HTRANS[0]};

    // Byte lanes covered by a transfer: every lane inside the size-aligned
    // block containing the start lane. Oversized transfers light every lane.
    function automatic logic [NBYTES-1:0] calc_strb(input logic [ADDRWIDTH-1:0] a,
                                                     input logic [2:0]           sz);
        int                lane;
        int                s;
        logic [NBYTES-1:0] m;
        lane = int'(a) % LANE_SPAN;
        s    = int'(sz);
        m    = '0;
        if ((1 << s) > NBYTES) begin
            m = '1;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                m[i] = ((i >> s) == (lane >> s));
            end
        end
        return m;
    endfunction

    assign accept    = (state == ST_IDLE) && HSEL && HTRANS[1] && HREADY;
    assign idx_valid = (NUM_SLAVES == 1) || (32'(idx_reg) < NUM_SLAVES);
    assign sel_ready = PREADY[idx_reg];
    assign sel_err   = PSLVERR[idx_reg];
    assign sel_rdata = PRDATA[int'(idx_reg)*DATAWIDTH +: DATAWIDTH];
    assign strb_calc = calc_strb(addr_reg, size_reg);

    assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign APBACTIVE = (state != ST_IDLE);

    // One-hot decode of the registered slave index.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (32'(idx_reg) == i);
        end
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. APB phases move only on PCLKEN edges; the error
    // states always run at full HCLK rate so the AHB response is two cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_PEND;
            ST_PEND:   if (PCLKEN) state_nxt = idx_valid ? ST_SETUP : ST_ERR1;
            ST_SETUP:  if (PCLKEN) state_nxt = ST_ACCESS;
            ST_ACCESS: if (PCLKEN && sel_ready) state_nxt = sel_err ? ST_ERR1 : ST_IDLE;
            ST_ERR1:   state_nxt = ST_ERR2;
            ST_ERR2:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and APB output registers. Write data arrives one cycle
    // after the address phase, hence the separate first-PEND-cycle capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            size_reg   <= '0;
            prot_reg   <= '0;
            idx_reg    <= '0;
            pend_first <= 1'b0;
            HRDATA     <= '0;
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            PPROT      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg   <= HADDR;
                        write_reg  <= HWRITE;
                        size_reg   <= HSIZE;
                        prot_reg   <= HPROT[1:0];
                        idx_reg    <= (NUM_SLAVES == 1) ? '0 : HADDR[SLV_ADDR_LSB +: IDX_W];
                        pend_first <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (pend_first) begin
                        PWDATA     <= HWDATA;
                        pend_first <= 1'b0;
                    end
                    if (PCLKEN && idx_valid) begin
                        PSEL    <= sel_onehot;
                        PENABLE <= 1'b0;
                        PADDR   <= addr_reg;
                        PWRITE  <= write_reg;
                        PSTRB   <= write_reg ? strb_calc : '0;
                        PPROT   <= {~prot_reg[0], 1'b0, prot_reg[1]};
                    end
                end
                ST_SETUP: begin
                    if (PCLKEN) PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PCLKEN && sel_ready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (!sel_err && !write_reg) HRDATA <= sel_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
